// File: rtl/wdog_pkg.sv
`default_nettype none
// ============================================================================
//  Module : wdog_pkg
//  Brief  : Shared types and constants for the regime watchdog.
//           Regime codes are one-hot, as produced by the eigenvalue core.
//  Rev    : 1.0  initial release
// ============================================================================
package wdog_pkg;

   localparam logic [2:0] REGIME_UNDER = 3'b001;
   localparam logic [2:0] REGIME_CRIT  = 3'b010;
   localparam logic [2:0] REGIME_OVER  = 3'b100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      ARMED = 2'd2,
      TRIP  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ALM_NONE    = 2'b00,
      ALM_STALL   = 2'b01,
      ALM_OSC     = 2'b10,
      ALM_INVALID = 2'b11
   } alarm_code_t;

   // A regime code is legal only if exactly one of the three classes is flagged.
   function automatic logic regime_legal(input logic [2:0] r);
      return (r == REGIME_UNDER) || (r == REGIME_CRIT) || (r == REGIME_OVER);
   endfunction

endpackage
`default_nettype wire

// File: rtl/wdog_window_calc.sv
`default_nettype none
// ============================================================================
//  Module : wdog_window_calc
//  Brief  : Converts the time constant |inv_kappa| (Q15.16) into a clamped
//           supervision window in cycles. Purely combinational; the top
//           registers the result while in LOAD.
//  Rev    : 1.0  initial release
// ============================================================================
module wdog_window_calc
   import wdog_pkg::*;
#(
   parameter int F        = 16,
   parameter int TAU_MULT = 4,
   parameter int CNT_W    = 16,
   parameter int MIN_WIN  = 4,
   parameter int MAX_WIN  = 65535
) (
   input  logic [31:0]      inv_kappa,
   input  logic [2:0]       regime,
   output logic [CNT_W-1:0] window
);

   // 32-bit magnitude times a small multiplier fits comfortably in 48 bits.
   localparam int PW = 48;

   logic [31:0]   mag;
   logic [PW-1:0] prod;
   logic [PW-1:0] scaled;

   // Magnitude, scale to cycles, drop fraction, then clamp. Critical damping
   // has no meaningful time constant, so it gets the longest window.
   always_comb begin
      mag    = inv_kappa[31] ? (~inv_kappa + 32'd1) : inv_kappa;
      prod   = {{(PW-32){1'b0}}, mag} * PW'(TAU_MULT);
      scaled = prod >> F;
      if ((regime == REGIME_CRIT) || (inv_kappa == 32'd0))
         window = CNT_W'(MAX_WIN);
      else if (scaled < PW'(MIN_WIN))
         window = CNT_W'(MIN_WIN);
      else if (scaled > PW'(MAX_WIN))
         window = CNT_W'(MAX_WIN);
      else
         window = scaled[CNT_W-1:0];
   end

endmodule
`default_nettype wire

// File: rtl/regime_watchdog.sv
`default_nettype none
// ============================================================================
//  Module : regime_watchdog
//  Brief  : Supervises the eigenvalue core. Each completed solve reloads a
//           countdown sized from the result's time constant; a sticky alarm
//           flags a stalled core, persistent oscillation or an illegal regime.
//           Optional feature macro: REGIME_WDOG_HIST_EN adds regime_hist,
//           a shift register of captured regimes (newest in [2:0]).
//  Rev    : 1.0  initial release
// ============================================================================
module regime_watchdog
   import wdog_pkg::*;
#(
   parameter int F        = 16,
   parameter int TAU_MULT = 4,
   parameter int CNT_W    = 16,
   parameter int MIN_WIN  = 4,
   parameter int MAX_WIN  = 65535,
   parameter int OSC_LIM  = 3
`ifdef REGIME_WDOG_HIST_EN
   ,
   parameter int HIST_D   = 8
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             core_busy,
   input  logic [31:0]      kappa,
   input  logic [31:0]      inv_kappa,
   input  logic [2:0]       regime,
   input  logic             alarm_clr,
   output logic             alarm,
   output logic [1:0]       alarm_code,
   output logic             armed,
   output logic [CNT_W-1:0] window,
`ifdef REGIME_WDOG_HIST_EN
   output logic [3*HIST_D-1:0] regime_hist,
`endif
   output logic [31:0]      kappa_lat
);

   localparam int              OW         = $clog2(OSC_LIM + 1);
   localparam logic [OW-1:0]   OSC_LIM_V  = OW'(OSC_LIM);

   state_t            state_q, state_d;
   alarm_code_t       code_q, trip_code;
   logic              busy_q;
   logic              new_res;
   logic              capture, load_win, dec_cnt, do_trip, do_clear;
   logic [OW-1:0]     osc_q, osc_d;
   logic [CNT_W-1:0]  cnt_q, window_q, win_calc;
   logic [31:0]       inv_lat, kappa_q;
   logic [2:0]        regime_lat;
   logic              alarm_q;

   // Falling edge of core_busy marks a fresh result from the core.
   assign new_res = busy_q & ~core_busy;

   wdog_window_calc #(
      .F        (F),
      .TAU_MULT (TAU_MULT),
      .CNT_W    (CNT_W),
      .MIN_WIN  (MIN_WIN),
      .MAX_WIN  (MAX_WIN)
   ) u_calc (
      .inv_kappa (inv_lat),
      .regime    (regime_lat),
      .window    (win_calc)
   );

   // Busy edge detector history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      busy_q <= 1'b0;
      else if (ena) busy_q <= core_busy;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      state_q <= IDLE;
      else if (ena) state_q <= state_d;
   end

   // Next state, trip decision and datapath strobes.
   always_comb begin
      state_d   = state_q;
      capture   = 1'b0;
      load_win  = 1'b0;
      dec_cnt   = 1'b0;
      do_trip   = 1'b0;
      do_clear  = 1'b0;
      trip_code = ALM_NONE;
      osc_d     = osc_q;
      case (state_q)
         IDLE: begin
            if (new_res) begin
               capture = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            load_win = 1'b1;
            if (regime_legal(regime_lat) && (regime_lat == REGIME_UNDER))
               osc_d = (osc_q >= OSC_LIM_V) ? osc_q : osc_q + 1'b1;
            else
               osc_d = '0;
            if (!regime_legal(regime_lat)) begin
               do_trip   = 1'b1;
               trip_code = ALM_INVALID;
               state_d   = TRIP;
            end else if (osc_d >= OSC_LIM_V) begin
               do_trip   = 1'b1;
               trip_code = ALM_OSC;
               state_d   = TRIP;
            end else begin
               state_d = ARMED;
            end
         end
         ARMED: begin
            // A fresh result on the expiry cycle still counts as on time.
            if (new_res) begin
               capture = 1'b1;
               state_d = LOAD;
            end else if (cnt_q == '0) begin
               do_trip   = 1'b1;
               trip_code = ALM_STALL;
               state_d   = TRIP;
            end else begin
               dec_cnt = 1'b1;
            end
         end
         TRIP: begin
            if (alarm_clr) begin
               do_clear = 1'b1;
               osc_d    = '0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Result capture registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kappa_q    <= '0;
         inv_lat    <= '0;
         regime_lat <= '0;
      end else if (ena && capture) begin
         kappa_q    <= kappa;
         inv_lat    <= inv_kappa;
         regime_lat <= regime;
      end
   end

   // Window load and supervision countdown.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         window_q <= '0;
         cnt_q    <= '0;
      end else if (ena) begin
         if (load_win) begin
            window_q <= win_calc;
            cnt_q    <= win_calc;
         end else if (dec_cnt) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   // Consecutive-underdamped counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      osc_q <= '0;
      else if (ena) osc_q <= osc_d;
   end

   // Sticky alarm; a trip always takes precedence over a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alarm_q <= 1'b0;
         code_q  <= ALM_NONE;
      end else if (ena) begin
         if (do_trip) begin
            alarm_q <= 1'b1;
            code_q  <= trip_code;
         end else if (do_clear) begin
            alarm_q <= 1'b0;
            code_q  <= ALM_NONE;
         end
      end
   end

`ifdef REGIME_WDOG_HIST_EN
   logic [3*HIST_D-1:0] hist_q;

   // Regime history, pushed on every accepted capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  hist_q <= '0;
      else if (ena && capture)  hist_q <= {hist_q[3*HIST_D-4:0], regime};
   end

   assign regime_hist = hist_q;
`endif

   assign alarm      = alarm_q;
   assign alarm_code = code_q;
   assign armed      = (state_q == ARMED);
   assign window     = window_q;
   assign kappa_lat  = kappa_q;

endmodule
`default_nettype wire
